alu_div_iter: RTL and testbench

Parametrised iterative integer divider; next generation of the fixed 32-bit ALU divider. It is generalised in operand width and in radix (bits retired per cycle). It adds asynchronous reset, explicit divide-by-zero and signed-overflow detection with defined results, and fast completion for those special cases. It sits under the integer ALU and keeps the existing enable / cpu_isStop / cplt handshake, so it drops in beside the multiplier.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/div_stage.sv | 27 ++
 rtl/alu_div_iter.sv | 210 +++++++++++++++++++++
 tb/tb_alu_div_iter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU divider.
//   div_state_e     : controller states (IDLE, CALC, DONE)
//   BPC_LEGAL_MASK  : bit n set when n quotient bits per cycle is supported
//   bpc_is_legal()  : elaboration-time check of a BPC value
//   abs_w()         : conditional two's-complement negate, ABS_MAX_W bits wide;
//                     callers zero-extend their operand in and truncate the result,
//                     which is exact because negation mod 2^W ignores upper bits.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [4:0] BPC_LEGAL_MASK = 5'b10110;
  localparam int         ABS_MAX_W      = 64;

  function automatic logic bpc_is_legal(input int bpc);
    if (bpc < 0 || bpc > 4) return 1'b0;
    return BPC_LEGAL_MASK[bpc];
  endfunction

  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] v,
                                                 input logic                 neg);
    return neg ? (~v + ABS_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_stage.sv
// One restoring-division step, purely combinational.
//   rem_i      : partial remainder entering the step (always < divisor_i)
//   dvd_bit_i  : next dividend bit, MSB first
//   divisor_i  : divisor magnitude
//   rem_o      : partial remainder after the step
//   q_bit_o    : quotient bit retired by the step
module div_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  // The shifted remainder is < 2*divisor, so the difference always fits in
  // WIDTH bits and can be taken modulo 2^WIDTH.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_div_iter.sv
// Iterative signed/unsigned integer divider, BPC quotient bits per cycle.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   enable      : level request, held high for the whole operation
//   cpu_isStop  : CPU stall; while high the finished result is held
//   mode        : 0 unsigned, 1 signed two's complement
//   x1, x2      : dividend, divisor (sampled once on the capture edge)
//   y, r        : quotient, remainder (registered)
//   cplt        : result valid
//   div_zero    : divisor was zero (y = all ones, r = x1)
//   ovf         : signed MIN / -1 (y = x1, r = 0)
//
// state | meaning
// IDLE  | waiting for enable; outputs cleared; operands captured on request
// CALC  | restoring division on magnitudes, cnt_q steps left
// DONE  | result and flags held until enable or cpu_isStop drops
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cpu_isStop,
  input  logic             mode,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r,
  output logic             cplt,
  output logic             div_zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  if (!bpc_is_legal(BPC) || WIDTH < 8 || (WIDTH % BPC) != 0 || WIDTH > ABS_MAX_W)
  begin : g_param_err
    $error("alu_div_iter: unsupported WIDTH/BPC combination");
  end

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             cplt_q, cplt_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  // dvd_q doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  logic [BPC:0][WIDTH-1:0] rem_chain;
  logic [BPC-1:0]          q_bits;
  logic [WIDTH-1:0]        dvd_next;
  logic [WIDTH-1:0]        quo_fin;
  logic [WIDTH-1:0]        rem_fin;
  logic [WIDTH-1:0]        abs_x1;
  logic [WIDTH-1:0]        abs_x2;
  logic                    x1_neg;
  logic                    x2_neg;

  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < BPC; i++) begin : g_stage
    div_stage #(.WIDTH(WIDTH)) u_stage (
      .rem_i     (rem_chain[i]),
      .dvd_bit_i (dvd_q[WIDTH-1-i]),
      .divisor_i (dvs_q),
      .rem_o     (rem_chain[i+1]),
      .q_bit_o   (q_bits[BPC-1-i])
    );
  end

  always_comb begin
    x1_neg   = mode & x1[WIDTH-1];
    x2_neg   = mode & x2[WIDTH-1];
    abs_x1   = WIDTH'(abs_w(ABS_MAX_W'(x1), x1_neg));
    abs_x2   = WIDTH'(abs_w(ABS_MAX_W'(x2), x2_neg));
    dvd_next = {dvd_q[WIDTH-BPC-1:0], q_bits};
    quo_fin  = WIDTH'(abs_w(ABS_MAX_W'(dvd_next), neg_quo_q));
    rem_fin  = WIDTH'(abs_w(ABS_MAX_W'(rem_chain[BPC]), neg_rem_q));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    y_d       = y_q;
    r_d       = r_q;
    cplt_d    = cplt_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (x2 == '0) begin
            y_d     = ONES_W;
            r_d     = x1;
            dz_d    = 1'b1;
            cplt_d  = 1'b1;
            state_d = DONE;
          end else if (mode && x1 == MIN_W && x2 == ONES_W) begin
            y_d     = x1;
            r_d     = '0;
            ovf_d   = 1'b1;
            cplt_d  = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d     = abs_x1;
            dvs_d     = abs_x2;
            rem_d     = '0;
            neg_quo_d = x1_neg ^ x2_neg;
            neg_rem_d = x1_neg;
            cnt_d     = CW'(STEPS);
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (!enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          dvd_d = dvd_next;
          rem_d = rem_chain[BPC];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            y_d     = quo_fin;
            r_d     = rem_fin;
            cplt_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (!enable || !cpu_isStop) begin
          y_d     = '0;
          r_d     = '0;
          cplt_d  = 1'b0;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        y_d     = '0;
        r_d     = '0;
        cplt_d  = 1'b0;
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      y_q       <= '0;
      r_q       <= '0;
      cplt_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      y_q       <= y_d;
      r_q       <= r_d;
      cplt_q    <= cplt_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign y        = y_q;
  assign r        = r_q;
  assign cplt     = cplt_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_alu_div_iter.sv
// Bench for alu_div_iter: six instances (WIDTH 32/16 x BPC 1/2/4) share one
// stimulus stream; each is compared against a plain-arithmetic reference.
module tb_alu_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cpu_isStop = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;

  always #5 clk = ~clk;

  logic [5:0][31:0] y_a, r_a;
  logic [5:0]       cplt_a, dz_a, ov_a;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int wk_of(input int k);
    return (k < 3) ? 32 : 16;
  endfunction

  function automatic int bk_of(input int k);
    return 1 << (k % 3);
  endfunction

  for (genvar k = 0; k < 6; k++) begin : g_dut
    localparam int WK = (k < 3) ? 32 : 16;
    localparam int BK = 1 << (k % 3);
    logic [WK-1:0] y_w, r_w;
    logic          c_w, d_w, o_w;

    alu_div_iter #(.WIDTH(WK), .BPC(BK)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cpu_isStop (cpu_isStop),
      .mode       (mode),
      .x1         (x1[WK-1:0]),
      .x2         (x2[WK-1:0]),
      .y          (y_w),
      .r          (r_w),
      .cplt       (c_w),
      .div_zero   (d_w),
      .ovf        (o_w)
    );

    assign y_a[k]    = 32'(y_w);
    assign r_a[k]    = 32'(r_w);
    assign cplt_a[k] = c_w;
    assign dz_a[k]   = d_w;
    assign ov_a[k]   = o_w;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Reference: division by plain integer arithmetic on the operand width.
  function automatic void model(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                input logic m, output logic [31:0] q, output logic [31:0] rm,
                                output logic dz, output logic ov);
    logic [31:0] mask, a, b;
    longint      sa, sb, min_v;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    dz = 1'b0;
    ov = 1'b0;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    min_v = -(longint'(1) << (w - 1));
    if (b == 0) begin
      q = mask; rm = a; dz = 1'b1;
    end else if (m && sa == min_v && sb == -1) begin
      q = a; rm = '0; ov = 1'b1;
    end else if (m) begin
      q  = 32'(sa / sb) & mask;
      rm = 32'(sa % sb) & mask;
    end else begin
      q  = a / b;
      rm = a % b;
    end
  endfunction

  task automatic check_idle(input string tag);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s k%0d", tag, k),
          {y_a[k] | r_a[k], 29'd0, cplt_a[k], dz_a[k], ov_a[k]}, 64'd0);
  endtask

  // Caller is at a falling edge; the next rising edge captures the operands.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input bit hold);
    logic [31:0] eq[6], er[6];
    logic        ed[6], eo[6];
    int          lat[6];
    int          exp_lat;
    bit          all_done;
    x1 = a; x2 = b; mode = m; enable = 1'b1; cpu_isStop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      model(wk_of(k), a, b, m, eq[k], er[k], ed[k], eo[k]);
      lat[k] = 0;
    end
    for (int e = 1; e <= 80; e++) begin
      @(negedge clk);
      if (e == 1) begin
        x1 = $urandom; x2 = $urandom; mode = 1'($urandom_range(0, 1));
      end
      all_done = 1'b1;
      for (int k = 0; k < 6; k++) begin
        if (lat[k] == 0 && cplt_a[k]) lat[k] = e;
        if (lat[k] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int k = 0; k < 6; k++) begin
      exp_lat = (ed[k] || eo[k]) ? 1 : wk_of(k) / bk_of(k) + 1;
      chk($sformatf("lat k%0d %h/%h", k, a, b), 64'(lat[k]), 64'(exp_lat));
      chk($sformatf("y k%0d %h/%h m%0d", k, a, b, m), 64'(y_a[k]), 64'(eq[k]));
      chk($sformatf("r k%0d %h/%h m%0d", k, a, b, m), 64'(r_a[k]), 64'(er[k]));
      chk($sformatf("flags k%0d %h/%h m%0d", k, a, b, m),
          64'({cplt_a[k], dz_a[k], ov_a[k]}), 64'({1'b1, ed[k], eo[k]}));
    end
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
          chk($sformatf("hold_y k%0d", k), 64'(y_a[k]), 64'(eq[k]));
          chk($sformatf("hold_r k%0d", k), 64'(r_a[k]), 64'(er[k]));
          chk($sformatf("hold_cplt k%0d", k), 64'(cplt_a[k]), 64'd1);
        end
      end
    end
  endtask

  task automatic release_op(input bit via_stop);
    if (via_stop) cpu_isStop = 1'b0;
    else          enable     = 1'b0;
    @(negedge clk);
    check_idle(via_stop ? "release_stop" : "release_en");
  endtask

  task automatic watch_no_cplt(input string tag, input int cycles);
    bit seen[6], nz[6];
    for (int k = 0; k < 6; k++) begin seen[k] = 1'b0; nz[k] = 1'b0; end
    repeat (cycles) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        if (cplt_a[k]) seen[k] = 1'b1;
        if (y_a[k] != 0 || r_a[k] != 0 || dz_a[k] || ov_a[k]) nz[k] = 1'b1;
      end
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_cplt k%0d", tag, k), 64'(seen[k]), 64'd0);
      chk($sformatf("%s_out k%0d", tag, k), 64'(nz[k]), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, 1'b0);               release_op(1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);         release_op(1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);         release_op(1'b1);
    run_op(32'd5, 32'd0, 1'b1, 1'b0);                 release_op(1'b0);
    run_op(32'd5, 32'd0, 1'b0, 1'b0);                 release_op(1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); release_op(1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);         release_op(1'b0);
    run_op(32'h0000_8000, 32'hFFFF_FFFF, 1'b1, 1'b0); release_op(1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0); release_op(1'b0);

    // abort mid-calculation: every instance is still in CALC after 3 edges
    x1 = $urandom; x2 = $urandom_range(1, 255); mode = 1'b0;
    enable = 1'b1; cpu_isStop = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    watch_no_cplt("abort", 40);

    // asynchronous reset while results are held
    run_op(32'd12345, 32'd3, 1'b0, 1'b0);
    #2 rst_n = 1'b0; enable = 1'b0;
    #1 check_idle("rst_done");
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset mid-calculation
    x1 = 32'd99999; x2 = 32'd7; mode = 1'b0; enable = 1'b1; cpu_isStop = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; enable = 1'b0;
    #1 check_idle("rst_calc");
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_cplt("post_rst", 40);

    run_op(32'd1000, 32'd10, 1'b0, 1'b0); release_op(1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_8000;
      run_op(a, b, 1'($urandom_range(0, 1)), 1'b0);
      release_op(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
